// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC conversion sequencer: auto-zero, fixed-time integrate and
// reference de-integrate, with a BCD decade counter and a latched BCD result.
module dual_slope_ctrl #(
  parameter int DIGITS    = 3,
  parameter int AZ_CYCLES = 100
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  cmp_i,
  input  logic                  pol_i,
  output logic                  sw_az_o,
  output logic                  sw_vin_o,
  output logic                  sw_vref_p_o,
  output logic                  sw_vref_n_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   result_o,
  output logic                  overrange_o,
  output logic                  neg_o
);

  localparam int CW = 4 * DIGITS;
  localparam int TW = (AZ_CYCLES > 1) ? $clog2(AZ_CYCLES) : 1;
  localparam logic [TW-1:0] AZ_LOAD = TW'(AZ_CYCLES - 1);

  function automatic logic [CW-1:0] all_nines();
    logic [CW-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'd9;
    return r;
  endfunction

  localparam logic [CW-1:0] ALL9 = all_nines();

  // Ripple-carry BCD increment; each decade wraps 9 -> 0 and carries upward.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_AUTOZERO,
    S_INTEGRATE,
    S_DEINT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   result_q, result_d;
  logic            ovr_q, ovr_d;
  logic            neg_q, neg_d;
  logic            cmp_meta_q, cmp_s_q;
  logic            pol_meta_q, pol_s_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      result_q   <= '0;
      ovr_q      <= 1'b0;
      neg_q      <= 1'b0;
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
      pol_meta_q <= 1'b0;
      pol_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      result_q   <= result_d;
      ovr_q      <= ovr_d;
      neg_q      <= neg_d;
      cmp_meta_q <= cmp_i;
      cmp_s_q    <= cmp_meta_q;
      pol_meta_q <= pol_i;
      pol_s_q    <= pol_meta_q;
    end
  end

  // Outputs depend only on registered state (and the latched polarity).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    result_d    = result_q;
    ovr_d       = ovr_q;
    neg_d       = neg_q;
    sw_az_o     = 1'b0;
    sw_vin_o    = 1'b0;
    sw_vref_p_o = 1'b0;
    sw_vref_n_o = 1'b0;
    busy_o      = 1'b1;
    valid_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        sw_az_o = 1'b1;
        busy_o  = 1'b0;
        if (start_i) begin
          state_d = S_AUTOZERO;
          tmr_d   = AZ_LOAD;
        end
      end
      S_AUTOZERO: begin
        sw_az_o = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_INTEGRATE;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_INTEGRATE: begin
        sw_vin_o = 1'b1;
        if (cnt_q == ALL9) begin
          neg_d   = pol_s_q;
          cnt_d   = '0;
          state_d = S_DEINT;
        end else begin
          cnt_d = bcd_inc(cnt_q);
        end
      end
      S_DEINT: begin
        // Reference polarity is opposite to the input to ramp back to zero.
        sw_vref_n_o = ~neg_q;
        sw_vref_p_o = neg_q;
        if (!cmp_s_q) begin
          result_d = cnt_q;
          ovr_d    = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_q == ALL9) begin
          result_d = ALL9;
          ovr_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = bcd_inc(cnt_q);
        end
      end
      S_DONE: begin
        valid_o = 1'b1;
        sw_az_o = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result_o    = result_q;
  assign overrange_o = ovr_q;
  assign neg_o       = neg_q;

endmodule
